// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store port.
package lsu_pkg;

  localparam int unsigned LSU_XLEN = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  // Number of RAM beats for a legal size.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_nbytes = 3'd1;
      SZ_HALF: size_nbytes = 3'd2;
      default: size_nbytes = 3'd4;
    endcase
  endfunction

  // Misalignment or reserved size.
  function automatic logic req_error(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: req_error = 1'b0;
      SZ_HALF: req_error = addr_lo[0];
      SZ_WORD: req_error = (addr_lo != 2'b00);
      default: req_error = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load to the full register width.
module load_extend
  import lsu_pkg::*;
(
  input  logic [1:0]          size_i,
  input  logic                uns_i,
  input  logic [LSU_XLEN-1:0] data_i,
  output logic [LSU_XLEN-1:0] data_o
);

  logic sign_b;
  logic sign_h;

  assign sign_b = ~uns_i & data_i[7];
  assign sign_h = ~uns_i & data_i[15];

  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_BYTE: data_o = {{(LSU_XLEN - 8){sign_b}}, data_i[7:0]};
      SZ_HALF: data_o = {{(LSU_XLEN - 16){sign_h}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_byte_port.sv
// Splits 32-bit loads/stores into byte beats on an 8-bit RAM port, one beat per cycle.
module lsu_byte_port
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [31:0]         req_addr_i,
  input  logic [31:0]         req_wdata_i,
  output logic                rsp_valid_o,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wren_o,
  output logic [7:0]          mem_wdata_o,
  input  logic [7:0]          mem_rdata_i
);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LSU_XLEN-1:0]   wdata_q, wdata_d;
  logic [LSU_XLEN-1:0]   asm_q, asm_d;
  logic                  err_q, err_d;

  logic [2:0]            nbytes;
  logic                  last_beat;
  logic [LSU_XLEN-1:0]   ext_data;
  logic                  unused_addr;

  assign unused_addr = ^req_addr_i[31:ADDR_W];

  assign nbytes    = size_nbytes(size_q);
  assign last_beat = ({1'b0, cnt_q} == (nbytes - 3'd1));

  load_extend u_load_extend (
    .size_i (size_q),
    .uns_i  (uns_q),
    .data_i (asm_q),
    .data_o (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    err_d       = err_q;

    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wren_o  = 1'b0;
    mem_wdata_o = '0;

    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i[ADDR_W-1:0];
          wdata_d = req_wdata_i;
          cnt_d   = 2'd0;
          asm_d   = '0;
          err_d   = req_error(req_size_i, req_addr_i[1:0]);
          state_d = err_d ? S_RESP : S_ACCESS;
        end
      end

      S_ACCESS: begin
        // Base address wraps modulo the RAM size.
        mem_addr_o = addr_q + ADDR_W'(cnt_q);
        mem_wren_o = we_q;
        if (we_q) begin
          mem_wdata_o = wdata_q[8*cnt_q +: 8];
        end else begin
          asm_d[8*cnt_q +: 8] = mem_rdata_i;
        end
        cnt_d = cnt_q + 2'd1;
        if (last_beat) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        if (!err_q && !we_q) begin
          rsp_rdata_o = ext_data;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_byte_port.sv
// Directed and randomized checks of lsu_byte_port against a byte-array memory model.
module tb_lsu_byte_port;

  localparam int MEM_SZ = 16384;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [13:0] mem_addr_o;
  logic        mem_wren_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;

  bit [7:0] ram     [MEM_SZ];
  bit [7:0] ref_mem [MEM_SZ];

  int tests_run = 0;
  int failed    = 0;

  lsu_byte_port #(.ADDR_W(14)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wren_o     (mem_wren_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide RAM with combinational read.
  assign mem_rdata_i = ram[mem_addr_o];
  always @(posedge clk) begin
    if (mem_wren_o) ram[mem_addr_o] <= mem_wdata_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ram_idx(input logic [31:0] a, input int i);
    return (int'(a & 32'h3FFF) + i) % MEM_SZ;
  endfunction

  // Reference load: little-endian value, then numeric sign handling.
  function automatic logic [31:0] model_load(input int nb, input bit uns, input logic [31:0] a);
    longint v;
    v = 0;
    for (int i = 0; i < nb; i++) v += longint'(ref_mem[ram_idx(a, i)]) << (8 * i);
    if (!uns && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic do_req(input bit we, input bit [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    bit          err;
    int          nb;
    logic [31:0] exp_rd;
    logic [31:0] wd;
    err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_rd = (!we && !err) ? model_load(nb, uns, addr) : 32'h0;
    wd = wdata;

    @(negedge clk);
    chk({tag, ":ready"}, {31'b0, req_ready_o}, 32'd1);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    @(negedge clk);
    req_valid_i    = 1'b0;
    req_we_i       = 1'($urandom);
    req_size_i     = 2'($urandom);
    req_unsigned_i = 1'($urandom);
    req_addr_i     = $urandom;
    req_wdata_i    = $urandom;

    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        chk({tag, ":addr"}, {18'b0, mem_addr_o}, 32'(ram_idx(addr, i)));
        chk({tag, ":wren"}, {31'b0, mem_wren_o}, {31'b0, we});
        chk({tag, ":vld_early"}, {31'b0, rsp_valid_o}, 32'd0);
        if (we) chk({tag, ":wdata"}, {24'b0, mem_wdata_o}, {24'b0, wd[7:0]});
        wd = wd >> 8;
        @(negedge clk);
      end
    end
    chk({tag, ":rsp_valid"}, {31'b0, rsp_valid_o}, 32'd1);
    chk({tag, ":rsp_err"}, {31'b0, rsp_err_o}, {31'b0, err});
    chk({tag, ":rsp_rdata"}, rsp_rdata_o, exp_rd);
    chk({tag, ":wren_resp"}, {31'b0, mem_wren_o}, 32'd0);
    chk({tag, ":addr_resp"}, {18'b0, mem_addr_o}, 32'd0);

    if (we && !err) begin
      for (int i = 0; i < nb; i++) ref_mem[ram_idx(addr, i)] = wdata[8*i +: 8];
    end

    @(negedge clk);
    chk({tag, ":ready_after"}, {31'b0, req_ready_o}, 32'd1);
    chk({tag, ":vld_once"}, {31'b0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    rst_i          = 1'b1;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'd0;
    req_unsigned_i = 1'b0;
    req_addr_i     = 32'h0;
    req_wdata_i    = 32'h0;

    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst:ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst:rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst:rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst:rsp_err", {31'b0, rsp_err_o}, 32'd0);
    chk("rst:wren", {31'b0, mem_wren_o}, 32'd0);
    chk("rst:addr", {18'b0, mem_addr_o}, 32'd0);
    chk("rst:wdata", {24'b0, mem_wdata_o}, 32'd0);

    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, "st_word");
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, "ld_word");
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, "ld_byte_s");
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, "ld_byte_u");
    do_req(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, "ld_half_s");
    do_req(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, "ld_half_u");
    do_req(1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'h1234_5678, "err_half");
    do_req(1'b1, 2'd3, 1'b0, 32'h0000_0100, 32'h1234_5678, "err_rsvd");
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0, "err_word");
    do_req(1'b1, 2'd0, 1'b0, 32'h0001_4000, 32'h0000_005A, "st_wrap");
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_0000, 32'h0, "ld_wrap");
    do_req(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFE, 32'h0, "ld_top");

    // Abort a word store after two beats have been committed.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_size_i  = 2'd2;
    req_addr_i  = 32'h0000_0200;
    req_wdata_i = 32'h1122_3344;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("abort:wren_in_rst", {31'b0, mem_wren_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    chk("abort:ready", {31'b0, req_ready_o}, 32'd1);
    chk("abort:no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    ref_mem[16'h200] = 8'h44;
    ref_mem[16'h201] = 8'h33;
    @(negedge clk);
    chk("abort:no_rsp2", {31'b0, rsp_valid_o}, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, "abort_ld");

    for (int n = 0; n < 80; n++) begin
      bit          we;
      bit [1:0]    sz;
      bit          uns;
      logic [31:0] a;
      we  = 1'($urandom);
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'h0000_003F;
      if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
      do_req(we, sz, uns, a, $urandom, "rand");
    end

    for (int i = 0; i < 64; i++) do_req(1'b0, 2'd0, 1'b1, 32'(i), 32'h0, "sweep");

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/lsu_byte_port.md
# lsu_byte_port

Load/store initiator that turns 32-bit pipeline memory requests (byte, halfword, word) into a sequence of single-byte accesses on the 8-bit, 16K-deep data RAM port. It sits between the MEM stage and the byte-wide data memory. It drives the RAM's address, write-enable and write-data inputs, and it samples the RAM's combinational read data. Loads are assembled little-endian and sign- or zero-extended before they are returned.

## Interface
Parameters:
- ADDR_W, 14, byte-address width of the data RAM; upper request address bits are ignored.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk_i  in  1  clock.
  - rst_i  in  1  asynchronous, active-high reset.
- Request side:
  - req_valid_i  in  1  request present.
  - req_ready_o  out  1  block can accept a request this cycle.
  - req_we_i  in  1  1 = store, 0 = load.
  - req_size_i  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
  - req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
  - req_addr_i  in  32  byte address.
  - req_wdata_i  in  32  store data; bytes taken from the LSB upward.
- Response side:
  - rsp_valid_o  out  1  one-cycle response pulse.
  - rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
  - rsp_err_o  out  1  misaligned access or reserved size.
- RAM side:
  - mem_addr_o  out  ADDR_W  RAM byte address.
  - mem_wren_o  out  1  RAM write enable.
  - mem_wdata_o  out  8  RAM write byte.
  - mem_rdata_i  in  8  RAM read byte; combinational from mem_addr_o.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - req_ready_o is 1 only in IDLE.
  - A request is accepted on the edge where req_valid_i and req_ready_o are both high.
  - On accept, the block latches we, size, unsigned, addr[ADDR_W-1:0] and wdata, and clears byte counter cnt (2 bits).
- Error check at accept:
  - Halfword with addr[0]=1 is an error.
  - Word with addr[1:0]≠0 is an error.
  - size=11 is an error.
  - On error: IDLE→RESP directly, rsp_err_o=1, no RAM access.
  - Otherwise: IDLE→ACCESS with nbytes = 1, 2 or 4.
- ACCESS, one byte per cycle:
  - mem_addr_o = base + cnt, truncated modulo 2^ADDR_W.
  - Store: mem_wren_o=1, mem_wdata_o = wdata[8·cnt+7:8·cnt].
  - Load: mem_wren_o=0; mem_rdata_i is captured into lane cnt of the assembly register at the clock edge.
  - cnt increments each cycle; when cnt = nbytes-1 the FSM goes ACCESS→RESP.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, then RESP→IDLE.
  - Load data: the byte/half/word is taken from the assembly register, then sign- or zero-extended to 32 bits.
  - Store data: rsp_rdata_o=0.
- Outside ACCESS: mem_wren_o=0, mem_addr_o=0, mem_wdata_o=0.

## Timing
- Accept edge is cycle 0.
  - ACCESS occupies cycles 1..nbytes.
  - rsp_valid_o is high in cycle nbytes+1.
  - req_ready_o returns high in cycle nbytes+2.
- Latencies to response: byte 2 cycles, half 3, word 5, error 1.
- Throughput with req_valid_i held high: one request per nbytes+2 cycles. There is no overlap of RESP with a new accept.
- Request inputs are don't-care outside the accept cycle; latched copies are used throughout.
- Reset values:
  - State IDLE, cnt=0, assembly register 0.
  - req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - mem_wren_o=0, mem_addr_o=0, mem_wdata_o=0.
- Reset mid-operation aborts immediately:
  - Bytes already written stay in the RAM.
  - No response is issued.
  - req_ready_o=1 from the first cycle after reset deassertion.
- Address wrap: address bits [31:ADDR_W] are ignored, so 0x0001_0000 maps to RAM byte 0.

## Structure
- Package lsu_pkg holds:
  - Size enum: SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum: S_IDLE, S_ACCESS, S_RESP.
  - Constant LSU_XLEN=32.
- One natural combinational sub-module, load_extend: (size, unsigned, 32-bit assembled) → 32-bit extended result.
- The RAM itself is instantiated outside this block by the parent.

## Test plan
- Word store 0xDEADBEEF to 0x100:
  - Cycles 1–4: mem_wren_o=1 with address/data 0x100/EF, 0x101/BE, 0x102/AD, 0x103/DE.
  - Cycle 5: rsp_valid_o=1, rsp_err_o=0, rsp_rdata_o=0.
- Word load from 0x100 after that store → rsp_rdata_o=0xDEADBEEF in cycle 5, with mem_wren_o never asserted.
- Byte load from 0x103:
  - Signed → 0xFFFFFFDE.
  - Unsigned → 0x000000DE.
  - Halfword signed load from 0x102 → 0xFFFFDEAD.
- Errors:
  - Halfword store to 0x101 → rsp_err_o=1 in cycle 1, mem_wren_o never high.
  - size=11 → same response.
- Address truncation: byte store 0x5A to 0x0001_4000 → mem_addr_o=0x0000; a byte load from 0x0 then returns 0x5A.
- Reset mid-store:
  - Word store 0x11223344 to 0x200, rst_i asserted during cycle 3.
  - Only 0x200=44 and 0x201=33 are written.
  - No rsp_valid_o; req_ready_o=1 after reset.
  - A new request is then accepted normally.
